// File: rtl/mem_arbiter.sv
// Arbitrates the shared single-port memory between instruction fetch and load/store.
// Data port wins contention unless fetch has lost STARVE_LIMIT times in a row.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              dm_valid,
    output logic              dm_ready,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic              dm_we,
    input  logic [3:0]        dm_wstrb,
    input  logic [31:0]       dm_wdata,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    owner_t     resp_owner;
    logic       resp_err;
    logic       resp_store;
    logic [3:0] starve_cnt;

    logic if_fault;
    logic dm_fault;
    logic grant_if;
    logic grant_dm;

    assign if_fault = (if_addr[1:0] != 2'b00);

    // Strobe pattern doubles as the access size for loads as well as stores.
    always_comb begin
        dm_fault = 1'b0;
        case (dm_wstrb)
            4'b1111:          dm_fault = (dm_addr[1:0] != 2'b00);
            4'b0011, 4'b1100: dm_fault = dm_addr[0];
            default:          dm_fault = 1'b0;
        endcase
    end

    assign grant_dm = rst_n && dm_valid && !(if_valid && (starve_cnt == LIMIT));
    assign grant_if = rst_n && if_valid && !grant_dm;
    assign if_ready = grant_if;
    assign dm_ready = grant_dm;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wstrb = 4'b0000;
        mem_addr  = if_addr;
        mem_wdata = dm_wdata;
        if (grant_dm) begin
            mem_en    = !dm_fault;
            mem_we    = dm_we && !dm_fault;
            mem_wstrb = dm_wstrb;
            mem_addr  = dm_addr;
        end else if (grant_if) begin
            mem_en    = !if_fault;
            mem_wstrb = 4'b1111;
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_owner <= OWN_NONE;
            resp_err   <= 1'b0;
            resp_store <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            if (grant_dm) begin
                resp_owner <= OWN_DM;
                resp_err   <= dm_fault;
                resp_store <= dm_we;
            end else if (grant_if) begin
                resp_owner <= OWN_IF;
                resp_err   <= if_fault;
                resp_store <= 1'b0;
            end else begin
                resp_owner <= OWN_NONE;
                resp_err   <= 1'b0;
                resp_store <= 1'b0;
            end

            // Counter can only reach LIMIT here; at LIMIT fetch wins and clears it.
            if (grant_if) begin
                starve_cnt <= 4'd0;
            end else if (if_valid && grant_dm && (starve_cnt != LIMIT)) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign if_rvalid = (resp_owner == OWN_IF);
    assign dm_rvalid = (resp_owner == OWN_DM);
    assign if_err    = if_rvalid && resp_err;
    assign dm_err    = dm_rvalid && resp_err;
    assign if_rdata  = (if_rvalid && !resp_err) ? mem_rdata : 32'd0;
    assign dm_rdata  = (dm_rvalid && !resp_err && !resp_store) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model
// with its own byte-array image of memory.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic              clk;
    logic              rst_n;
    logic              if_valid, if_ready, if_rvalid, if_err;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              dm_valid, dm_ready, dm_we, dm_rvalid, dm_err;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_wstrb;
    logic [31:0]       dm_wdata, dm_rdata;
    logic              mem_en, mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_valid(dm_valid), .dm_ready(dm_ready), .dm_addr(dm_addr),
        .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory macro stand-in: 256 bytes, 1-cycle read latency.
    logic [7:0] stub [0:255];
    logic       stub_loaded = 1'b0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'(i * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (!stub_loaded) begin
            for (int i = 0; i < 256; i++) stub[i] <= init_byte(i);
            stub_loaded <= 1'b1;
        end else if (mem_en) begin
            int base;
            base = {24'd0, mem_addr[7:2], 2'b00};
            if (mem_we) begin
                for (int l = 0; l < 4; l++)
                    if (mem_wstrb[l]) stub[base + l] <= mem_wdata[8*l +: 8];
            end
            mem_rdata <= {stub[base + 3], stub[base + 2], stub[base + 1], stub[base]};
        end
    end

    // Reference model state
    logic [7:0] refm [0:255];
    int         losses;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       g_if, g_dm;

    logic              p_if_v, p_dm_v, p_dm_we;
    logic [ADDR_W-1:0] p_if_a, p_dm_a;
    logic [3:0]        p_dm_s;
    logic [31:0]       p_dm_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [ADDR_W-1:0] a);
        int b;
        b = int'(a[7:0]) & ~3;
        return {refm[b + 3], refm[b + 2], refm[b + 1], refm[b]};
    endfunction

    function automatic logic dm_misaligned(input logic [ADDR_W-1:0] a, input logic [3:0] s);
        if (s == 4'b1111) return (a % 4) != 0;
        if (s == 4'b0011 || s == 4'b1100) return (a % 2) != 0;
        return 1'b0;
    endfunction

    // One clock of traffic: check grant-cycle outputs, then the response one edge later.
    task automatic cycle();
        logic        e_if, e_dm, mis, exp_en;
        int          owner;
        logic        r_err;
        logic [31:0] r_data;
        int          b;
        if_valid = p_if_v; if_addr = p_if_a;
        dm_valid = p_dm_v; dm_addr = p_dm_a; dm_we = p_dm_we;
        dm_wstrb = p_dm_s; dm_wdata = p_dm_d;
        #1;
        e_dm = p_dm_v && !(p_if_v && losses == LIMIT);
        e_if = p_if_v && !e_dm;
        chk("if_ready", 32'(if_ready), 32'(e_if));
        chk("dm_ready", 32'(dm_ready), 32'(e_dm));
        mis = e_dm ? dm_misaligned(p_dm_a, p_dm_s) : (p_if_a % 4) != 0;
        exp_en = (e_if || e_dm) && !mis;
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        owner = 0; r_err = 1'b0; r_data = 32'd0;
        if (exp_en) begin
            chk("mem_addr", mem_addr, e_dm ? p_dm_a : p_if_a);
            chk("mem_we", 32'(mem_we), 32'(e_dm && p_dm_we));
            if (e_dm && p_dm_we) begin
                chk("mem_wstrb", 32'(mem_wstrb), 32'(p_dm_s));
                chk("mem_wdata", mem_wdata, p_dm_d);
            end
        end
        if (e_dm) begin
            owner = 2; r_err = mis;
            if (!mis && !p_dm_we) r_data = ref_word(p_dm_a);
            if (!mis && p_dm_we) begin
                b = int'(p_dm_a[7:0]) & ~3;
                for (int l = 0; l < 4; l++)
                    if (p_dm_s[l]) refm[b + l] = p_dm_d[8*l +: 8];
            end
        end else if (e_if) begin
            owner = 1; r_err = mis;
            if (!mis) r_data = ref_word(p_if_a);
        end
        if (e_if) losses = 0;
        else if (p_if_v && e_dm && losses < LIMIT) losses++;
        g_if = e_if; g_dm = e_dm;
        @(posedge clk); #1;
        chk("if_rvalid", 32'(if_rvalid), 32'(owner == 1));
        chk("dm_rvalid", 32'(dm_rvalid), 32'(owner == 2));
        if (owner == 1) begin
            chk("if_err", 32'(if_err), 32'(r_err));
            chk("if_rdata", if_rdata, r_data);
        end
        if (owner == 2) begin
            chk("dm_err", 32'(dm_err), 32'(r_err));
            chk("dm_rdata", dm_rdata, r_data);
        end
        $display("t=%0t grant if=%0b dm=%0b resp_owner=%0d err=%0b data=%h", $time, e_if, e_dm, owner, r_err, r_data);
    endtask

    initial begin
        logic [9:0]  pattern;
        logic [31:0] merged;
        logic [3:0]  strobes [8];
        strobes = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        for (int i = 0; i < 256; i++) refm[i] = init_byte(i);
        losses = 0;

        // Reset with both requesters asserting
        rst_n = 1'b0;
        p_if_v = 1'b1; p_if_a = 32'h10; p_dm_v = 1'b1; p_dm_a = 32'h20;
        p_dm_we = 1'b0; p_dm_s = 4'b1111; p_dm_d = 32'd0;
        if_valid = 1'b1; if_addr = p_if_a; dm_valid = 1'b1; dm_addr = p_dm_a;
        dm_we = 1'b0; dm_wstrb = 4'b1111; dm_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_dm_ready", 32'(dm_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rst_err", {30'd0, if_err, dm_err}, 32'd0);
        chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_dm_ready", 32'(dm_ready), 32'd1);
        cycle();

        // Fetch-only stream
        p_dm_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            p_if_v = 1'b1; p_if_a = 32'(4 * k);
            cycle();
        end
        p_if_v = 1'b0;
        cycle();

        // Half-word store then full-word load of the same word
        p_dm_v = 1'b1; p_dm_a = 32'h8; p_dm_we = 1'b1; p_dm_s = 4'b0011; p_dm_d = 32'hDEADBEEF;
        cycle();
        chk("store_ack_rdata", dm_rdata, 32'd0);
        p_dm_we = 1'b0; p_dm_s = 4'b1111;
        cycle();
        merged = {init_byte(11), init_byte(10), 16'hBEEF};
        chk("load_merged", dm_rdata, merged);
        p_dm_v = 1'b0;
        cycle();

        // Sustained contention: dm x4 then if, repeating
        p_if_v = 1'b1; p_if_a = 32'h40;
        cycle();
        p_dm_v = 1'b1; p_dm_we = 1'b0; p_dm_s = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            p_dm_a = 32'(32'h80 + 4 * k);
            p_if_a = 32'(32'h44 + 4 * k);
            cycle();
            pattern[k] = g_if;
        end
        chk("starve_pattern", 32'(pattern), 32'b10_0001_0000);
        p_if_v = 1'b0; p_dm_v = 1'b0;
        cycle();

        // Misaligned requests are accepted but answered with an error
        p_if_v = 1'b1; p_if_a = 32'h2;
        cycle();
        chk("mis_if_err", 32'(if_err), 32'd1);
        p_if_v = 1'b0;
        p_dm_v = 1'b1; p_dm_a = 32'h3; p_dm_we = 1'b0; p_dm_s = 4'b1111;
        cycle();
        chk("mis_dm_err", 32'(dm_err), 32'd1);
        p_dm_a = 32'h5; p_dm_we = 1'b1; p_dm_s = 4'b0011; p_dm_d = 32'h12345678;
        cycle();
        p_dm_a = 32'h4; p_dm_we = 1'b0; p_dm_s = 4'b1111;
        cycle();
        p_dm_v = 1'b0;

        // Reset during the response cycle of an accepted load
        if_valid = 1'b0; dm_valid = 1'b1; dm_addr = 32'h30; dm_we = 1'b0; dm_wstrb = 4'b1111;
        #1;
        chk("pre_reset_dm_ready", 32'(dm_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        dm_valid = 1'b0;
        #1;
        chk("reset_kills_rvalid", 32'(dm_rvalid), 32'd0);
        chk("reset_kills_rdata", dm_rdata, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        losses = 0;
        @(posedge clk); #1;
        chk("no_stale_resp", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

        // Randomized traffic; requests are held until accepted
        p_if_v = 1'b0; p_dm_v = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!(p_if_v && !g_if)) begin
                p_if_v = ($urandom_range(0, 3) != 0);
                p_if_a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                if ($urandom_range(0, 7) == 0) p_if_a[1:0] = 2'($urandom_range(1, 3));
            end
            if (!(p_dm_v && !g_dm)) begin
                p_dm_v = ($urandom_range(0, 2) != 0);
                p_dm_we = $urandom_range(0, 1) == 1;
                p_dm_s = strobes[$urandom_range(0, 7)];
                p_dm_d = $urandom;
                p_dm_a = {24'd0, 8'($urandom_range(0, 255))};
                if ($urandom_range(0, 3) != 0 && p_dm_s == 4'b1111) p_dm_a[1:0] = 2'b00;
            end
            g_if = 1'b0; g_dm = 1'b0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
